// File: rtl/sw_conditioner.sv
// sw_conditioner: sync, debounce and edge-detect a raw switch bus.
// in: clk, rst(n), SW | out: sw_clean, sw_rise/fall, sw_changed, step_pulse, sample_tick
module sw_conditioner #(
  parameter int WIDTH          = 16,
  parameter int SAMPLE_DIV     = 200000,
  parameter int STABLE_SAMPLES = 4,
  parameter int STEP_BIT       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed,
  output logic             step_pulse,
  output logic             sample_tick
);

  localparam int CW = (SAMPLE_DIV > 1) ?
                      $clog2(SAMPLE_DIV) : 1;
  localparam int HW = STABLE_SAMPLES - 1;
  localparam int SW_W = STABLE_SAMPLES;
  localparam logic [CW-1:0] DIV_LAST =
    CW'(SAMPLE_DIV - 1);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [CW-1:0]    div_cnt_q, div_cnt_d;
  logic             tick_q, tick_d;
  logic             tick;

  logic [WIDTH-1:0][HW-1:0] hist_q, hist_d;
  logic [WIDTH-1:0][SW_W-1:0] win;

  logic [WIDTH-1:0] clean_q, clean_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             chg_q, chg_d;

  // tick is decoded from the live count; tick_q is the
  // registered copy that lines up with the same cycle.
  always_comb begin
    sync1_d   = SW;
    sync2_d   = sync1_q;
    tick      = (div_cnt_q == DIV_LAST);
    div_cnt_d = tick ? '0 : div_cnt_q + CW'(1);
    tick_d    = (div_cnt_d == DIV_LAST);
  end

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      win[i] = {hist_q[i], sync2_q[i]};
    end
  end

  always_comb begin
    hist_d  = hist_q;
    clean_d = clean_q;
    rise_d  = '0;
    fall_d  = '0;
    if (tick) begin
      for (int i = 0; i < WIDTH; i++) begin
        // shift: oldest sample drops out the top
        hist_d[i] = win[i][HW-1:0];
        if ((&win[i]) && !clean_q[i]) begin
          clean_d[i] = 1'b1;
          rise_d[i]  = 1'b1;
        end else if (!(|win[i]) && clean_q[i]) begin
          clean_d[i] = 1'b0;
          fall_d[i]  = 1'b1;
        end
      end
    end
    chg_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      div_cnt_q <= '0;
      tick_q    <= 1'b0;
      hist_q    <= '0;
      clean_q   <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      chg_q     <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      div_cnt_q <= div_cnt_d;
      tick_q    <= tick_d;
      hist_q    <= hist_d;
      clean_q   <= clean_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      chg_q     <= chg_d;
    end
  end

  assign sw_clean    = clean_q;
  assign sw_rise     = rise_q;
  assign sw_fall     = fall_q;
  assign sw_changed  = chg_q;
  assign step_pulse  = rise_q[STEP_BIT];
  assign sample_tick = tick_q;

endmodule

// File: tb/tb_sw_conditioner.sv
// tb_sw_conditioner: scoreboard bench for sw_conditioner.
// Main DUT: SAMPLE_DIV=4, STABLE=3, STEP_BIT=3; second DUT: SAMPLE_DIV=1.
module tb_sw_conditioner;

  typedef struct {
    int          lo;
    int          hi;
    logic [15:0] rise;
    logic [15:0] fall;
    logic [15:0] clean;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] sw  = '0;
  logic [15:0] sw_clean, sw_rise, sw_fall;
  logic        sw_changed, step_pulse, sample_tick;

  logic [15:0] sw2 = '0;
  logic [15:0] clean2, rise2, fall2;
  logic        chg2, step2, tick2;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   rise5_n  = 0;
  int   step_n   = 0;
  exp_t sb[$];
  exp_t me;

  always #5 clk = ~clk;

  sw_conditioner #(
    .WIDTH(16), .SAMPLE_DIV(4),
    .STABLE_SAMPLES(3), .STEP_BIT(3)
  ) u_dut (
    .clk(clk), .rst(rst), .SW(sw),
    .sw_clean(sw_clean), .sw_rise(sw_rise),
    .sw_fall(sw_fall), .sw_changed(sw_changed),
    .step_pulse(step_pulse),
    .sample_tick(sample_tick)
  );

  sw_conditioner #(
    .WIDTH(16), .SAMPLE_DIV(1),
    .STABLE_SAMPLES(3), .STEP_BIT(2)
  ) u_dut1 (
    .clk(clk), .rst(rst), .SW(sw2),
    .sw_clean(clean2), .sw_rise(rise2),
    .sw_fall(fall2), .sw_changed(chg2),
    .step_pulse(step2),
    .sample_tick(tick2)
  );

  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // first sampling edge that sees a change driven at edge e
  function automatic int first_tick(input int e);
    int t;
    t = e + 3;
    while (t % 4 != 0) t++;
    return t;
  endfunction

  function automatic void push(input int lo, input int hi,
                               input logic [15:0] r,
                               input logic [15:0] f,
                               input logic [15:0] c);
    exp_t x;
    x.lo = lo; x.hi = hi;
    x.rise = r; x.fall = f; x.clean = c;
    sb.push_back(x);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (sw_rise[5]) rise5_n++;
      if (step_pulse) step_n++;
      if ((sw_rise | sw_fall) != '0) begin
        if (sb.size() == 0) begin
          chk("spur_rise", sw_rise, 0);
          chk("spur_fall", sw_fall, 0);
        end else begin
          me = sb.pop_front();
          chk("rise", sw_rise, me.rise);
          chk("fall", sw_fall, me.fall);
          chk("clean", sw_clean, me.clean);
          chk("changed", sw_changed, 1);
          chk("step", step_pulse, me.rise[3]);
          if (me.lo == me.hi)
            chk("pulse_edge", cyc, me.lo);
          else
            chk("pulse_edge_in_range",
                (cyc >= me.lo && cyc <= me.hi), 1);
        end
      end else begin
        chk("changed_idle", sw_changed, 0);
      end
    end
  end

  task automatic drive(input logic [15:0] v,
                       output int e);
    @(posedge clk);
    #1;
    sw = v;
    e = cyc;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("sb_drain", sb.size(), 0);
    repeat (4) @(posedge clk);
  endtask

  initial begin
    int e;
    int t;

    // reset values with switches already up
    sw = 16'hFFFF;
    repeat (3) @(negedge clk);
    chk("rst_clean", sw_clean, 0);
    chk("rst_rise", sw_rise, 0);
    chk("rst_fall", sw_fall, 0);
    chk("rst_chg", sw_changed, 0);
    chk("rst_step", step_pulse, 0);
    chk("rst_tick", sample_tick, 0);
    chk("rst_tick1", tick2, 0);
    rst = 1'b1;
    push(11, 14, 16'hFFFF, 16'h0000, 16'hFFFF);
    drain(40);
    chk("clean_ffff", sw_clean, 16'hFFFF);

    // all switches down
    drive(16'h0000, e);
    t = first_tick(e) + 8;
    push(t, t, 16'h0000, 16'hFFFF, 16'h0000);
    drain(40);

    // clean press of SW[3] one cycle before a tick
    step_n = 0;
    @(negedge clk);
    while (cyc % 4 != 0) @(negedge clk);
    drive(16'h0008, e);
    chk("press_phase", e % 4, 1);
    push(e + 11, e + 11, 16'h0008, 16'h0000, 16'h0008);
    drain(40);
    chk("step_count", step_n, 1);

    // short glitch on SW[5]
    rise5_n = 0;
    drive(16'h0028, e);
    repeat (6) @(posedge clk);
    #1 sw = 16'h0008;
    repeat (20) @(posedge clk);
    #1 chk("glitch_clean", sw_clean, 16'h0008);
    chk("glitch_rise5", rise5_n, 0);

    // bounce every 3 cycles, then settle high
    for (int k = 0; k < 14; k++) begin
      sw[5] = ~sw[5];
      repeat (3) @(posedge clk);
      #1;
    end
    sw[5] = 1'b0;
    repeat (8) @(posedge clk);
    drive(16'h0028, e);
    t = first_tick(e) + 8;
    push(t, t, 16'h0020, 16'h0000, 16'h0028);
    drain(40);
    chk("bounce_rise5", rise5_n, 1);

    // move to 000F, then swap to 00F0 in one cycle
    drive(16'h000F, e);
    t = first_tick(e) + 8;
    push(t, t, 16'h0007, 16'h0020, 16'h000F);
    drain(40);
    drive(16'h00F0, e);
    t = first_tick(e) + 8;
    push(t, t, 16'h00F0, 16'h000F, 16'h00F0);
    drain(40);
    chk("swap_clean", sw_clean, 16'h00F0);

    // reset in the middle of debouncing SW[0]
    drive(16'h0000, e);
    t = first_tick(e) + 8;
    push(t, t, 16'h0000, 16'h00F0, 16'h0000);
    drain(40);
    drive(16'h0001, e);
    t = first_tick(e) + 4;
    @(negedge clk);
    while (cyc < t) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("mid_rst_clean", sw_clean, 0);
      chk("mid_rst_rise", sw_rise, 0);
      chk("mid_rst_tick", sample_tick, 0);
    end
    rst = 1'b1;
    push(12, 12, 16'h0001, 16'h0000, 16'h0001);
    drain(40);

    // sample tick pattern of both instances
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("tick4", sample_tick, (cyc % 4 == 3));
      chk("tick1", tick2, 1);
    end

    // SAMPLE_DIV=1 step on SW[2]
    @(posedge clk);
    #1 sw2 = 16'h0004;
    e = cyc;
    @(negedge clk);
    while (cyc < e + 4) @(negedge clk);
    chk("div1_early", clean2, 16'h0000);
    @(negedge clk);
    chk("div1_clean", clean2, 16'h0004);
    chk("div1_rise", rise2, 16'h0004);
    chk("div1_step", step2, 1);
    chk("div1_chg", chg2, 1);
    @(negedge clk);
    chk("div1_rise_off", rise2, 16'h0000);

    chk("sb_final", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
